// File: rtl/divisor_secuencial_pkg.sv
// Shared definitions for the sequential signed divider and sibling
// sequential arithmetic blocks: default width, FSM state encoding and
// iteration-counter sizing.
package divisor_secuencial_pkg;

  // Default operand/result width; the dividend is twice this wide.
  localparam int N_DEF = 8;

  // State encoding reused by the sequential arithmetic blocks.
  localparam int EST_W = 2;

  typedef enum logic [EST_W-1:0] {
    EST_IDLE = 2'd0,
    EST_CALC = 2'd1,
    EST_FIX  = 2'd2,
    EST_DONE = 2'd3
  } estado_t;

  // Width of the iteration counter that walks the 2n dividend bits.
  function automatic int cnt_ancho(input int n);
    return $clog2(2 * n) + 1;
  endfunction

endpackage

// File: rtl/divisor_secuencial_if.sv
// Request/result bundle of the sequential divider. The master drives the
// operands and start; the slave (the divider) returns results and status.
interface divisor_secuencial_if
  import divisor_secuencial_pkg::*;
#(
  parameter int N = N_DEF
);

  logic                  start;
  logic signed [2*N-1:0] dividendo;
  logic signed [N-1:0]   divisor;
  logic signed [N-1:0]   cociente;
  logic signed [N-1:0]   residuo;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic                  div_cero;

  modport master (
    output start, dividendo, divisor,
    input  cociente, residuo, busy, done, overflow, div_cero
  );

  modport slave (
    input  start, dividendo, divisor,
    output cociente, residuo, busy, done, overflow, div_cero
  );

endinterface

// File: rtl/divisor_secuencial_valor_absoluto.sv
// Combinational magnitude of a signed value. The magnitude is one bit wider
// than the input so the most negative value converts without wrapping.
module valor_absoluto
  import divisor_secuencial_pkg::*;
#(
  parameter int W = 2 * N_DEF
) (
  input  logic [W-1:0] valor,
  output logic [W:0]   magnitud,
  output logic         signo
);

  logic [W:0] extendido_s;

  // Sign-extend by one bit, then negate when the input is negative.
  always_comb begin
    signo       = valor[W-1];
    extendido_s = {valor[W-1], valor};
    if (signo) begin
      magnitud = (~extendido_s) + {{W{1'b0}}, 1'b1};
    end else begin
      magnitud = extendido_s;
    end
  end

endmodule

// File: rtl/divisor_secuencial.sv
// Sequential signed divider: 2N-bit dividend by N-bit divisor, restoring
// division on magnitudes (one quotient bit per clock, MSB first), then sign
// fix-up with saturation and divide-by-zero reporting.
module divisor_secuencial
  import divisor_secuencial_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  divisor_secuencial_if.slave   bus
);

  localparam int CW = cnt_ancho(N);
  localparam logic [CW-1:0]  ULTIMA  = CW'(2 * N - 1);
  localparam logic [2*N-1:0] LIM_POS = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic [2*N-1:0] LIM_NEG = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]   MAX_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]   MIN_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]   UNO_N   = {{(N-1){1'b0}}, 1'b1};

  estado_t        estado_q, estado_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] quo_q, quo_d;         // dividend magnitude shifting out, quotient shifting in
  logic [2*N-1:0] rem_q, rem_d;         // partial remainder
  logic [N:0]     dvs_mag_q, dvs_mag_d;
  logic           sgn_coc_q, sgn_coc_d; // quotient sign
  logic           sgn_res_q, sgn_res_d; // remainder sign = dividend sign
  logic           cero_q, cero_d;
  logic [N-1:0]   cociente_q, cociente_d;
  logic [N-1:0]   residuo_q, residuo_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           overflow_q, overflow_d;
  logic           div_cero_q, div_cero_d;

  logic [2*N:0]   dvd_mag_s;
  logic           dvd_neg_s;
  logic [N:0]     dvs_mag_s;
  logic           dvs_neg_s;
  logic [2*N:0]   desplazado_s;
  logic [2*N:0]   resta_s;
  logic           bit_q_s;
  logic           ovf_s;
  logic [N-1:0]   coc_fix_s;
  logic [N-1:0]   res_fix_s;

  valor_absoluto #(.W(2 * N)) u_abs_dividendo (
    .valor    (bus.dividendo),
    .magnitud (dvd_mag_s),
    .signo    (dvd_neg_s)
  );

  valor_absoluto #(.W(N)) u_abs_divisor (
    .valor    (bus.divisor),
    .magnitud (dvs_mag_s),
    .signo    (dvs_neg_s)
  );

  // One restoring step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    desplazado_s = {rem_q, quo_q[2*N-1]};
    resta_s      = desplazado_s - {{N{1'b0}}, dvs_mag_q};
    bit_q_s      = ~resta_s[2*N];
  end

  // Sign application and range check on the finished magnitudes.
  always_comb begin
    if (sgn_coc_q) begin
      ovf_s     = (quo_q > LIM_NEG);
      coc_fix_s = (~quo_q[N-1:0]) + UNO_N;
    end else begin
      ovf_s     = (quo_q > LIM_POS);
      coc_fix_s = quo_q[N-1:0];
    end
    if (sgn_res_q) begin
      res_fix_s = (~rem_q[N-1:0]) + UNO_N;
    end else begin
      res_fix_s = rem_q[N-1:0];
    end
  end

  // Next-state and next-output logic of the control FSM.
  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_mag_d  = dvs_mag_q;
    sgn_coc_d  = sgn_coc_q;
    sgn_res_d  = sgn_res_q;
    cero_d     = cero_q;
    cociente_d = cociente_q;
    residuo_d  = residuo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    div_cero_d = div_cero_q;
    case (estado_q)
      EST_IDLE: begin
        if (bus.start) begin
          // The top magnitude bit is always zero; it seeds the remainder so
          // the whole 2N+1-bit magnitude takes part in the division.
          quo_d     = dvd_mag_s[2*N-1:0];
          rem_d     = {{(2*N-1){1'b0}}, dvd_mag_s[2*N]};
          dvs_mag_d = dvs_mag_s;
          sgn_coc_d = dvd_neg_s ^ dvs_neg_s;
          sgn_res_d = dvd_neg_s;
          cero_d    = (bus.divisor == {N{1'b0}});
          cnt_d     = {CW{1'b0}};
          busy_d    = 1'b1;
          estado_d  = EST_CALC;
        end else begin
          estado_d  = EST_IDLE;
        end
      end
      EST_CALC: begin
        quo_d = {quo_q[2*N-2:0], bit_q_s};
        if (bit_q_s) begin
          rem_d = resta_s[2*N-1:0];
        end else begin
          rem_d = desplazado_s[2*N-1:0];
        end
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == ULTIMA) begin
          estado_d = EST_FIX;
        end else begin
          estado_d = EST_CALC;
        end
      end
      EST_FIX: begin
        if (cero_q) begin
          cociente_d = sgn_res_q ? MIN_NEG : MAX_POS;
          residuo_d  = {N{1'b0}};
          overflow_d = 1'b0;
          div_cero_d = 1'b1;
        end else if (ovf_s) begin
          cociente_d = sgn_coc_q ? MIN_NEG : MAX_POS;
          residuo_d  = {N{1'b0}};
          overflow_d = 1'b1;
          div_cero_d = 1'b0;
        end else begin
          cociente_d = coc_fix_s;
          residuo_d  = res_fix_s;
          overflow_d = 1'b0;
          div_cero_d = 1'b0;
        end
        estado_d = EST_DONE;
      end
      EST_DONE: begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        estado_d = EST_IDLE;
      end
      default: begin
        busy_d   = 1'b0;
        estado_d = EST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= EST_IDLE;
      cnt_q      <= {CW{1'b0}};
      quo_q      <= {(2*N){1'b0}};
      rem_q      <= {(2*N){1'b0}};
      dvs_mag_q  <= {(N+1){1'b0}};
      sgn_coc_q  <= 1'b0;
      sgn_res_q  <= 1'b0;
      cero_q     <= 1'b0;
      cociente_q <= {N{1'b0}};
      residuo_q  <= {N{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      div_cero_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_mag_q  <= dvs_mag_d;
      sgn_coc_q  <= sgn_coc_d;
      sgn_res_q  <= sgn_res_d;
      cero_q     <= cero_d;
      cociente_q <= cociente_d;
      residuo_q  <= residuo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      div_cero_q <= div_cero_d;
    end
  end

  assign bus.cociente = cociente_q;
  assign bus.residuo  = residuo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.div_cero = div_cero_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed and random bench for divisor_secuencial (N=8, 16-bit dividend).
// Expected results come from an integer reference model and are queued when
// an operation is issued, then popped when done pulses.
module tb_divisor_secuencial;

  localparam int N = 8;
  localparam int LAT = 2 * N + 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  divisor_secuencial_if #(.N(N)) bus_if ();

  divisor_secuencial #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    logic signed [7:0] q;
    logic signed [7:0] r;
    logic              ovf;
    logic              dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t modelo(input longint a, input longint b);
    exp_t   e;
    longint q;
    longint r;
    logic signed [7:0] maxp;
    logic signed [7:0] minn;
    maxp  = 8'h7F;
    minn  = 8'h80;
    e.dz  = 1'b0;
    e.ovf = 1'b0;
    e.r   = 8'sd0;
    if (b == 0) begin
      e.dz = 1'b1;
      e.q  = (a >= 0) ? maxp : minn;
    end else begin
      q = a / b;
      r = a % b;
      if (q > 127) begin
        e.q = maxp; e.ovf = 1'b1;
      end else if (q < -128) begin
        e.q = minn; e.ovf = 1'b1;
      end else begin
        e.q = q[7:0];
        e.r = r[7:0];
      end
    end
    return e;
  endfunction

  task automatic chk_ceros(input string tag);
    check({tag, " cociente"}, bus_if.cociente, 0);
    check({tag, " residuo"},  bus_if.residuo, 0);
    check({tag, " busy"},     {63'd0, bus_if.busy}, 0);
    check({tag, " done"},     {63'd0, bus_if.done}, 0);
    check({tag, " overflow"}, {63'd0, bus_if.overflow}, 0);
    check({tag, " div_cero"}, {63'd0, bus_if.div_cero}, 0);
  endtask

  task automatic run_op(input longint a, input longint b, input bit cambia,
                        input string tag);
    int   k;
    exp_t e;
    sb.push_back(modelo(a, b));
    @(negedge clk);
    bus_if.start     = 1'b1;
    bus_if.dividendo = 16'(a);
    bus_if.divisor   = 8'(b);
    @(negedge clk);
    bus_if.start = 1'b0;
    if (cambia) begin
      bus_if.dividendo = 16'($urandom);
      bus_if.divisor   = 8'($urandom);
    end
    k = 0;
    while (bus_if.done !== 1'b1 && k < 40) begin
      check({tag, " busy"}, {63'd0, bus_if.busy}, 1);
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, k, LAT);
    check({tag, " busy@done"}, {63'd0, bus_if.busy}, 0);
    e = sb.pop_front();
    check({tag, " cociente"}, bus_if.cociente, e.q);
    check({tag, " residuo"},  bus_if.residuo, e.r);
    check({tag, " overflow"}, {63'd0, bus_if.overflow}, {63'd0, e.ovf});
    check({tag, " div_cero"}, {63'd0, bus_if.div_cero}, {63'd0, e.dz});
    @(negedge clk);
    check({tag, " done pulse"}, {63'd0, bus_if.done}, 0);
  endtask

  initial begin
    int   ciclo;
    int   dones;
    int   t_done [3];
    exp_t e;
    longint a;
    longint b;

    reset            = 1'b1;
    bus_if.start     = 1'b0;
    bus_if.dividendo = 16'sd0;
    bus_if.divisor   = 8'sd0;
    repeat (3) @(negedge clk);
    chk_ceros("reset");
    reset = 1'b0;

    // Basic division, signs, saturation and divide-by-zero.
    run_op(100, 7, 1'b0, "100/7");
    run_op(-100, 7, 1'b0, "-100/7");
    run_op(100, -7, 1'b0, "100/-7");
    run_op(-100, -7, 1'b0, "-100/-7");
    run_op(1000, 2, 1'b0, "1000/2");
    run_op(-256, 2, 1'b0, "-256/2");
    run_op(-32768, -1, 1'b0, "-32768/-1");
    run_op(5, 0, 1'b0, "5/0");
    run_op(-5, 0, 1'b0, "-5/0");
    run_op(100, 7, 1'b0, "flags clear");
    run_op(32767, 127, 1'b0, "max/127");
    run_op(-32768, 127, 1'b0, "min/127");

    // Operands changing while busy must not disturb the result.
    run_op(-12345, 99, 1'b1, "scramble");

    // start held high: one accepted operation every 2N+3 cycles.
    for (int i = 0; i < 3; i++) sb.push_back(modelo(-1234, 37));
    for (int i = 0; i < 3; i++) t_done[i] = 0;
    @(negedge clk);
    bus_if.start     = 1'b1;
    bus_if.dividendo = -16'sd1234;
    bus_if.divisor   = 8'sd37;
    ciclo = 0;
    dones = 0;
    while (dones < 3 && ciclo < 200) begin
      @(negedge clk);
      ciclo++;
      if (bus_if.done === 1'b1) begin
        t_done[dones] = ciclo;
        if (dones == 2) bus_if.start = 1'b0;
        e = sb.pop_front();
        check("held cociente", bus_if.cociente, e.q);
        check("held residuo", bus_if.residuo, e.r);
        dones++;
      end
    end
    bus_if.start = 1'b0;
    check("held count", dones, 3);
    check("held first", t_done[0], LAT + 1);
    check("held gap1", t_done[1] - t_done[0], LAT + 1);
    check("held gap2", t_done[2] - t_done[1], LAT + 1);
    @(negedge clk);
    check("held stop busy", {63'd0, bus_if.busy}, 0);

    // Reset during CALC aborts silently.
    @(negedge clk);
    bus_if.start     = 1'b1;
    bus_if.dividendo = 16'sd100;
    bus_if.divisor   = 8'sd7;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-reset busy", {63'd0, bus_if.busy}, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_ceros("mid reset");
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) dones++;
    end
    check("no done after reset", dones, 0);
    run_op(100, 7, 1'b0, "after reset");

    // Round trip with products of random factors.
    for (int i = 0; i < 1000; i++) begin
      a = longint'($urandom_range(0, 255)) - 128;
      b = longint'($urandom_range(0, 254)) - 128;
      if (b >= 0) b = b + 1;
      run_op(a * b, b, 1'b0, "roundtrip");
      check("roundtrip factor", bus_if.cociente, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divisor_secuencial.md
Name: divisor_secuencial

Overview:
- Sequential signed integer divider. It is the inverse operation of the combinational multiplier: it takes a 2N-bit signed dividend (a product-width value) and an N-bit signed divisor.
- It returns an N-bit quotient and an N-bit remainder, plus saturation/overflow and divide-by-zero flags.
- It uses an iterative restoring-division datapath, one quotient bit per clock, with a start/busy/done handshake.
- It sits in the arithmetic datapath next to the multiplier. Typical uses are fixed-point rescaling and recovering a factor from a product.

Parameters:
- N, default `N (shared width macro in constantes.h), operand/result width in bits; the dividend is 2N bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividendo  input  2N signed  dividend; sampled on the accepting edge
- divisor  input  N signed  divisor; sampled on the accepting edge
- cociente  output  N signed  quotient, registered
- residuo  output  N signed  remainder, registered
- busy  output  1  high from the cycle after acceptance until done
- done  output  1  single-cycle pulse; results valid from this cycle onward
- overflow  output  1  quotient saturated; valid with done, held until the next done
- div_cero  output  1  divisor was zero; valid with done, held until the next done

Behaviour:
- Reset (synchronous, active-high): state goes to IDLE; all outputs go to 0 (cociente, residuo, busy, done, overflow, div_cero).
- Reset has priority over everything. Asserting it mid-operation aborts the operation; nothing is reported.
- States:
  - IDLE: busy=0. If start=1, register the operands, their magnitudes and the result signs, then go to CALC.
  - CALC: 2N cycles. Each cycle shifts the 2N-bit partial remainder left with the next dividend magnitude bit, subtracts the divisor magnitude, and restores if the result is negative. This yields one quotient bit per cycle, MSB first. An iteration counter of ceil(log2(2N))+1 bits ends CALC after exactly 2N cycles.
  - FIX: apply signs and saturation, then register the outputs.
  - DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: start sampled at edge t gives done=1 in the cycle after edge t+2N+2. Divide-by-zero cases take the same latency; no early exit.
- Throughput: start can be accepted again in the cycle done is high? No. start is accepted only in IDLE, so back-to-back operations are spaced 2N+3 cycles apart.
- start while not in IDLE is ignored; no queueing.
- Operand inputs may change freely after acceptance.
- Arithmetic:
  - Truncation toward zero; the remainder takes the sign of the dividend; abs(residuo) < abs(divisor).
  - The magnitude of the most negative 2N-bit dividend is handled with a 2N+1-bit absolute value; no wrap.
  - Overflow: the true quotient is outside [-2^(N-1), 2^(N-1)-1]. Then cociente = 2^(N-1)-1 if the result sign is positive, -2^(N-1) if negative; residuo=0; overflow=1.
  - A quotient of exactly -2^(N-1) is legal (overflow=0).
  - Divisor = 0: div_cero=1, overflow=0, residuo=0, cociente = 2^(N-1)-1 for a dividend >= 0, otherwise -2^(N-1).
- cociente, residuo, overflow and div_cero change only on the edge that enters DONE, and hold until the next DONE or reset.

Decomposition:
- constantes.h already holds `N. Add the state encodings (IDLE, CALC, FIX, DONE) as `defines with a 2-bit state width so other sequential arithmetic blocks reuse them.
- One sub-module is natural: valor_absoluto. It is combinational, parameterised by width, and outputs the magnitude plus a sign bit.
- It is instantiated twice, once for the dividend (2N) and once for the divisor (N).
- Everything else stays in divisor_secuencial.

Test Plan (N=8, dividend 16-bit):
- 100 / 7 -> after 2N+2 cycles: done pulse, cociente=14, residuo=2, overflow=0, div_cero=0; busy high for the intermediate cycles.
- Signs: -100 / 7 -> -14, -2; 100 / -7 -> -14, 2; -100 / -7 -> 14, -2.
- Saturation: 1000 / 2 -> cociente=127, residuo=0, overflow=1. -256 / 2 -> cociente=-128, overflow=0. -32768 / -1 -> 127, overflow=1.
- Divide by zero:
  - 5 / 0 -> div_cero=1, cociente=127, residuo=0, same latency.
  - -5 / 0 -> cociente=-128.
  - The next valid op clears both flags.
- Handshake:
  - start held high throughout gives exactly one accepted op per 2N+3 cycles.
  - Changing the operands while busy does not alter the result.
  - Reset asserted at CALC cycle 5 gives all outputs 0 next edge and no done; a new start then completes normally.
- Round trip with the multiplier: random signed a,b (b!=0), dividendo = a*b -> cociente=a, residuo=0, overflow=0 over 1000 vectors.
